committer_nw: RTL

//  Parametrised N-wide in-order commit stage; successor to the fixed 2-wide/4-pipeline committer.

---
 rtl/committer_nw_if.sv | 45 ++++
 rtl/committer_nw.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/committer_nw_if.sv
// Commit-stage bundle: scoreboard peek/dequeue, per-pipeline results and the regfile/exception side.
// master drives scoreboard/pipeline inputs; slave is the commit stage itself.
interface committer_nw_if #(
    parameter int unsigned CmtW  = 2,
    parameter int unsigned NumPl = 4,
    parameter int unsigned RegW  = 32
);
    logic [CmtW-1:0]       sbd_valid_i;
    logic [CmtW*NumPl-1:0] sbd_pl_i;
    logic [CmtW-1:0]       sbd_rd_rdy_o;
    logic [NumPl-1:0]      pl_valid_i;
    logic [NumPl-1:0]      pl_err_i;
    logic [NumPl-1:0]      pl_we_i;
    logic [NumPl-1:0]      pl_wrsv_i;
    logic [NumPl*5-1:0]    pl_waddr_i;
    logic [NumPl*RegW-1:0] pl_wdata_i;
    logic [NumPl*32-1:0]   pl_pc_i;
    logic [NumPl*6-1:0]    pl_mcause_i;
    logic [NumPl*32-1:0]   pl_mtval_i;
    logic [NumPl-1:0]      pl_rdy_o;
    logic                  flush_i;
    logic [CmtW-1:0]       rf_we_o;
    logic [CmtW*5-1:0]     rf_waddr_o;
    logic [CmtW*RegW-1:0]  rf_wdata_o;
    logic [31:0]           cmt_regwr_o;
    logic                  cmt_err_o;
    logic [31:0]           err_pc_o;
    logic [5:0]            err_mcause_o;
    logic [31:0]           err_mtval_o;
    logic [63:0]           minstret_o;

    modport master (
        output sbd_valid_i, sbd_pl_i, pl_valid_i, pl_err_i, pl_we_i, pl_wrsv_i,
               pl_waddr_i, pl_wdata_i, pl_pc_i, pl_mcause_i, pl_mtval_i, flush_i,
        input  sbd_rd_rdy_o, pl_rdy_o, rf_we_o, rf_waddr_o, rf_wdata_o, cmt_regwr_o,
               cmt_err_o, err_pc_o, err_mcause_o, err_mtval_o, minstret_o
    );

    modport slave (
        input  sbd_valid_i, sbd_pl_i, pl_valid_i, pl_err_i, pl_we_i, pl_wrsv_i,
               pl_waddr_i, pl_wdata_i, pl_pc_i, pl_mcause_i, pl_mtval_i, flush_i,
        output sbd_rd_rdy_o, pl_rdy_o, rf_we_o, rf_waddr_o, rf_wdata_o, cmt_regwr_o,
               cmt_err_o, err_pc_o, err_mcause_o, err_mtval_o, minstret_o
    );
endinterface

// File: rtl/committer_nw.sv
// N-wide in-order commit: dequeue/regfile writes are combinational from the same cycle; exception hold and minstret are registered.
// A slot stalls (and stalls all younger slots) until its pipeline output is valid; nothing retires while an exception is held.
module committer_nw #(
    parameter int unsigned CmtW      = 2,
    parameter int unsigned NumPl     = 4,
    parameter int unsigned RegW      = 32,
    parameter bit          CHERIoTEn = 1'b0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    committer_nw_if.slave cmt
);
    typedef enum logic {RUN, ERR} state_e;

    state_e      state_q;
    logic [31:0] err_pc_q;
    logic [5:0]  err_mcause_q;
    logic [31:0] err_mtval_q;
    logic [63:0] minstret_q;

    logic [NumPl-1:0] sel    [CmtW];
    logic [4:0]       waddr  [CmtW];
    logic [RegW-1:0]  wdata  [CmtW];
    logic [31:0]      pc     [CmtW];
    logic [5:0]       mcause [CmtW];
    logic [31:0]      mtval  [CmtW];
    logic [CmtW-1:0]  plv, err, pwe, wrsv, rdy, cand, we;
    logic [NumPl-1:0] pl_rdy;
    logic [31:0]      regwr;
    logic             cap_vld;
    logic [31:0]      cap_pc, cap_mtval;
    logic [5:0]       cap_mcause;
    logic [63:0]      ret_cnt;
    logic             unused_cheri;

    assign unused_cheri = CHERIoTEn;

    // Per-slot view of its target pipeline; PL 0 supplies the fields when nothing is selected.
    always_comb begin : slot_decode
        for (int k = 0; k < CmtW; k++) begin
            sel[k]    = cmt.sbd_pl_i[k*NumPl +: NumPl];
            plv[k]    = |(sel[k] & cmt.pl_valid_i);
            err[k]    = |(sel[k] & cmt.pl_err_i);
            pwe[k]    = |(sel[k] & cmt.pl_we_i);
            wrsv[k]   = |(sel[k] & cmt.pl_wrsv_i);
            waddr[k]  = cmt.pl_waddr_i[4:0];
            wdata[k]  = cmt.pl_wdata_i[RegW-1:0];
            pc[k]     = cmt.pl_pc_i[31:0];
            mcause[k] = cmt.pl_mcause_i[5:0];
            mtval[k]  = cmt.pl_mtval_i[31:0];
            for (int p = NumPl - 1; p >= 0; p--) begin
                if (sel[k][p]) begin
                    waddr[k]  = cmt.pl_waddr_i[p*5 +: 5];
                    wdata[k]  = cmt.pl_wdata_i[p*RegW +: RegW];
                    pc[k]     = cmt.pl_pc_i[p*32 +: 32];
                    mcause[k] = cmt.pl_mcause_i[p*6 +: 6];
                    mtval[k]  = cmt.pl_mtval_i[p*32 +: 32];
                end
            end
        end
    end

    // The chain of older slots gates each slot: all older ready, none erroring, no shared PL.
    always_comb begin : readiness
        logic             chain_ok;
        logic [NumPl-1:0] used;
        chain_ok = (state_q == RUN) && !cmt.flush_i;
        used     = '0;
        rdy      = '0;
        pl_rdy   = '0;
        for (int k = 0; k < CmtW; k++) begin
            rdy[k]   = chain_ok & cmt.sbd_valid_i[k] & plv[k] & ~|(sel[k] & used);
            chain_ok = rdy[k] & ~err[k];
            used     = used | sel[k];
            pl_rdy   = pl_rdy | ({NumPl{rdy[k]}} & sel[k]);
        end
    end

    always_comb begin : write_ports
        for (int k = 0; k < CmtW; k++) begin
            cand[k] = rdy[k] & ~err[k] & pwe[k] & (waddr[k] != 5'd0);
        end
        we    = '0;
        regwr = '0;
        for (int k = 0; k < CmtW; k++) begin
            we[k] = cand[k];
            // A younger write to the same register supersedes this one.
            for (int j = k + 1; j < CmtW; j++) begin
                if (cand[j] && (waddr[j] == waddr[k])) we[k] = 1'b0;
            end
            if (we[k] && wrsv[k]) regwr[waddr[k]] = 1'b1;
        end
        regwr[0] = 1'b0;
    end

    always_comb begin : capture_and_count
        cap_vld    = 1'b0;
        cap_pc     = '0;
        cap_mcause = '0;
        cap_mtval  = '0;
        ret_cnt    = '0;
        for (int k = CmtW - 1; k >= 0; k--) begin
            if (rdy[k] && err[k]) begin
                cap_vld    = 1'b1;
                cap_pc     = pc[k];
                cap_mcause = mcause[k];
                cap_mtval  = mtval[k];
            end
            ret_cnt = ret_cnt + 64'(rdy[k] & ~err[k]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= RUN;
            err_pc_q     <= '0;
            err_mcause_q <= '0;
            err_mtval_q  <= '0;
            minstret_q   <= '0;
        end else begin
            minstret_q <= minstret_q + ret_cnt;
            case (state_q)
                RUN: if (cap_vld) begin
                    state_q      <= ERR;
                    err_pc_q     <= cap_pc;
                    err_mcause_q <= cap_mcause;
                    err_mtval_q  <= cap_mtval;
                end
                ERR: if (cmt.flush_i) state_q <= RUN;
                default: state_q <= RUN;
            endcase
        end
    end

    always_comb begin : pack_outputs
        cmt.rf_waddr_o = '0;
        cmt.rf_wdata_o = '0;
        for (int k = 0; k < CmtW; k++) begin
            cmt.rf_waddr_o[k*5 +: 5]       = waddr[k];
            cmt.rf_wdata_o[k*RegW +: RegW] = wdata[k];
        end
    end

    assign cmt.sbd_rd_rdy_o = rdy;
    assign cmt.pl_rdy_o     = pl_rdy;
    assign cmt.rf_we_o      = we;
    assign cmt.cmt_regwr_o  = regwr;
    assign cmt.cmt_err_o    = (state_q == ERR);
    assign cmt.err_pc_o     = err_pc_q;
    assign cmt.err_mcause_o = err_mcause_q;
    assign cmt.err_mtval_o  = err_mtval_q;
    assign cmt.minstret_o   = minstret_q;
endmodule
